// File: rtl/pipe_pkg.sv
// Shared types and widths for the CPU pipeline stage registers.
package pipe_pkg;

   // Occupancy of a stage register (FULL only exists with a skid entry)
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   // Default performance-counter width
   localparam int unsigned PIPE_CNT_W = 16;

   // Packed payload widths of the individual stage boundaries
   localparam int unsigned IF_ID_W   = 64;
   localparam int unsigned ID_EXE_W  = 170;
   localparam int unsigned EXE_MEM_W = 110;
   localparam int unsigned MEM_WB_W  = 72;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, reusable for performance monitoring.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic         w_sat;

   assign w_sat = &r_count;

   // Count up on inc, stick at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && !w_sat) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, flush
// for bubble insertion and a saturating stall-cycle counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned           WIDTH       = 170,
   parameter bit                    SKID        = 1'b1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
   parameter int unsigned           CNT_W       = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   pipe_state_t      r_state;
   pipe_state_t      w_state_nxt;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_load_in_main;
   logic             w_load_in_skid;
   logic             w_load_skid_main;
   logic             w_stall;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_skid;

   assign w_in_fire  = in_valid  & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_stall    = out_valid & ~out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and payload load selects; flush drops any same-cycle input
   always_comb begin
      w_state_nxt      = r_state;
      w_load_in_main   = 1'b0;
      w_load_in_skid   = 1'b0;
      w_load_skid_main = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_load_in_main = 1'b1;
                  w_state_nxt    = BUSY;
               end
            end
            BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_in_main = 1'b1;
               end else if (w_in_fire && SKID) begin
                  w_load_in_skid = 1'b1;
                  w_state_nxt    = FULL;
               end else if (w_in_fire) begin
                  // unreachable without skid: in_ready implies out_ready here
                  w_load_in_main = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (w_out_fire) begin
                  w_load_skid_main = 1'b1;
                  w_state_nxt      = BUSY;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
            end
         endcase
      end
   end

   // Handshake outputs; with a skid entry in_ready depends on state only
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      out_valid = (r_state != EMPTY);
      if (SKID) begin
         in_ready = (r_state != FULL);
      end else begin
         in_ready = (r_state == EMPTY) || out_ready;
      end
   end

   // Main payload register, always the source of out_data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= RESET_VALUE;
      end else if (w_load_in_main) begin
         r_main <= in_data;
      end else if (w_load_skid_main) begin
         r_main <= w_skid;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [WIDTH-1:0] r_skid;

         // Skid entry absorbs the beat accepted while out_ready was low
         always_ff @(posedge clk) begin
            if (rst) begin
               r_skid <= RESET_VALUE;
            end else if (w_load_in_skid) begin
               r_skid <= in_data;
            end
         end

         assign w_skid = r_skid;
      end else begin : g_no_skid
         assign w_skid = RESET_VALUE;
      end
   endgenerate

   assign out_data = r_main;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_stall),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid stage (3-bit stall counter)
// and one single-entry stage, each with an in-order payload scoreboard.
module tb_pipe_stage_reg;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst;

   logic         fl1, iv1, ir1, ov1, or1;
   logic [W-1:0] id1, od1;
   logic [2:0]   sc1;

   logic         fl0, iv0, ir0, ov0, or0;
   logic [W-1:0] id0, od0;
   logic [15:0]  sc0;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .WIDTH       (W),
      .SKID        (1'b1),
      .RESET_VALUE (16'hDEAD),
      .CNT_W       (3)
   ) u_dut_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl1),
      .in_valid  (iv1),
      .in_ready  (ir1),
      .in_data   (id1),
      .out_valid (ov1),
      .out_ready (or1),
      .out_data  (od1),
      .stall_cnt (sc1)
   );

   pipe_stage_reg #(
      .WIDTH       (W),
      .SKID        (1'b0),
      .RESET_VALUE (16'h0000),
      .CNT_W       (16)
   ) u_dut_noskid (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl0),
      .in_valid  (iv0),
      .in_ready  (ir0),
      .in_data   (id0),
      .out_valid (ov0),
      .out_ready (or0),
      .out_data  (od0),
      .stall_cnt (sc0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Settle, score handshakes of the coming edge, advance one cycle
   task automatic tick();
      logic [W-1:0] e;
      #1;
      if (ov1 && or1) begin
         if (q1.size() == 0) check("sb_skid_underflow", 32'(q1.size()), 32'd1);
         else begin
            e = q1.pop_front();
            check("sb_skid_data", 32'(od1), 32'(e));
         end
      end
      if (rst || fl1) q1.delete();
      else if (iv1 && ir1) q1.push_back(id1);
      if (ov0 && or0) begin
         if (q0.size() == 0) check("sb_noskid_underflow", 32'(q0.size()), 32'd1);
         else begin
            e = q0.pop_front();
            check("sb_noskid_data", 32'(od0), 32'(e));
         end
      end
      if (rst || fl0) q0.delete();
      else if (iv0 && ir0) q0.push_back(id0);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = '0;
      fl0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; id0 = '0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_out_valid", 32'(ov1), 32'd0);
      check("rst_in_ready",  32'(ir1), 32'd1);
      check("rst_out_data",  32'(od1), 32'hDEAD);
      check("rst_stall_cnt", 32'(sc1), 32'd0);
      check("rst0_out_valid", 32'(ov0), 32'd0);
      check("rst0_in_ready",  32'(ir0), 32'd1);

      // one-cycle latency
      iv1 = 1'b1; id1 = 16'h00A5;
      tick();
      iv1 = 1'b0;
      check("lat_out_valid", 32'(ov1), 32'd1);
      check("lat_out_data",  32'(od1), 32'h00A5);
      or1 = 1'b1;
      tick();

      // back-to-back streaming
      for (int i = 1; i <= 8; i++) begin
         iv1 = 1'b1; id1 = W'(i);
         tick();
         check("stream_valid", 32'(ov1), 32'd1);
         check("stream_data",  32'(od1), 32'(i));
      end
      iv1 = 1'b0;
      tick();
      check("stream_drain", 32'(ov1), 32'd0);
      check("stream_stall", 32'(sc1), 32'd0);

      // skid absorbs one beat when out_ready drops
      iv1 = 1'b1; id1 = 16'd1; or1 = 1'b1;
      tick();
      id1 = 16'd2;
      tick();
      id1 = 16'd3; or1 = 1'b0;
      tick();
      iv1 = 1'b0;
      check("skid_in_ready", 32'(ir1), 32'd0);
      check("skid_main",     32'(od1), 32'd2);
      check("skid_valid",    32'(ov1), 32'd1);
      or1 = 1'b1;
      tick();
      check("skid_pop_main",  32'(od1), 32'd3);
      check("skid_ready_back", 32'(ir1), 32'd1);
      tick();
      check("skid_empty", 32'(ov1), 32'd0);
      check("skid_stall", 32'(sc1), 32'd1);

      // flush from FULL with in_valid asserted
      or1 = 1'b0; iv1 = 1'b1; id1 = 16'd2;
      tick();
      id1 = 16'd3;
      tick();
      check("flush_full", 32'(ir1), 32'd0);
      fl1 = 1'b1; id1 = 16'd4;
      tick();
      fl1 = 1'b0; iv1 = 1'b0;
      check("flush_valid", 32'(ov1), 32'd0);
      check("flush_ready", 32'(ir1), 32'd1);
      check("flush_hold",  32'(od1), 32'd2);
      check("flush_stall", 32'(sc1), 32'd3);

      // flush discards a same-cycle in-fire
      iv1 = 1'b1; id1 = 16'd5;
      tick();
      fl1 = 1'b1; id1 = 16'd6;
      tick();
      fl1 = 1'b0; iv1 = 1'b0;
      check("flush2_valid", 32'(ov1), 32'd0);
      check("flush2_hold",  32'(od1), 32'd5);
      or1 = 1'b1;
      tick();
      check("flush2_no_out", 32'(ov1), 32'd0);
      check("flush2_stall",  32'(sc1), 32'd4);

      // stall counter saturation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("sat_rst", 32'(sc1), 32'd0);
      or1 = 1'b0; iv1 = 1'b1; id1 = 16'd7;
      tick();
      iv1 = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 3) check("sat_mid", 32'(sc1), 32'd3);
      end
      check("sat_max", 32'(sc1), 32'd7);
      or1 = 1'b1;
      tick();
      check("sat_hold", 32'(sc1), 32'd7);
      check("sat_drain", 32'(ov1), 32'd0);

      // single-entry stage: in_ready follows out_ready combinationally
      or0 = 1'b1; iv0 = 1'b1; id0 = 16'h0011;
      tick();
      iv0 = 1'b0; or0 = 1'b0;
      #1;
      check("ns_ready_low", 32'(ir0), 32'd0);
      or0 = 1'b1;
      #1;
      check("ns_ready_high", 32'(ir0), 32'd1);
      iv0 = 1'b1; id0 = 16'h0022;
      tick();
      id0 = 16'h0033; or0 = 1'b0;
      tick();
      check("ns_hold", 32'(od0), 32'h0022);
      or0 = 1'b1;
      tick();
      iv0 = 1'b0;
      tick();
      check("ns_empty", 32'(ov0), 32'd0);
      check("ns_stall", 32'(sc0), 32'd1);

      check("sb_skid_left",   32'(q1.size()), 32'd0);
      check("sb_noskid_left", 32'(q0.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
